// File: rtl/decode_iqueue_if.sv
// Decode-queue handshake bundle: fetch/self-instruction inputs and presented instruction/status outputs.
interface decode_iqueue_if #(
  parameter int INSTR_W = 16,
  parameter int DEPTH   = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [INSTR_W-1:0] instr_i;
  logic               instr_en_i;
  logic [INSTR_W-1:0] self_instr_i;
  logic               self_instr_en_i;
  logic               stall_i;
  logic               flush_i;
  logic [INSTR_W-1:0] instr_o;
  logic               instr_valid_o;
  logic [CW-1:0]      count_o;
  logic               stall_fetch_o;
  logic               overflow_o;

  modport slave (
    input  instr_i, instr_en_i, self_instr_i, self_instr_en_i, stall_i, flush_i,
    output instr_o, instr_valid_o, count_o, stall_fetch_o, overflow_o
  );

  modport master (
    output instr_i, instr_en_i, self_instr_i, self_instr_en_i, stall_i, flush_i,
    input  instr_o, instr_valid_o, count_o, stall_fetch_o, overflow_o
  );
endinterface

// File: rtl/decode_iqueue.sv
// Decode instruction queue: circular buffer with zero-latency bypass and head insertion of self-instructions.
// Output is combinational; stall_i holds the presented entry, stall_fetch_o throttles fetch one slot early.
module decode_iqueue #(
  parameter int                 INSTR_W   = 16,
  parameter int                 DEPTH     = 4,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(16'hffff)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  decode_iqueue_if.slave q_if
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef logic [AW-1:0] ptr_t;

  logic [INSTR_W-1:0] mem_q [DEPTH];
  ptr_t               head_q, head_d;
  ptr_t               tail_q, tail_d;
  logic [CW-1:0]      count_q, count_d;
  logic               ovf_q, ovf_d;

  logic               has_entry;
  logic               vld;
  logic [INSTR_W-1:0] instr_pres;
  logic               pop, pop_entry, bypass;
  logic               push_head_req, push_tail_req;
  logic               push_head, push_tail;
  logic [CW-1:0]      cnt_after, free_slots;
  ptr_t               head_pop, head_ins;

  assign has_entry = (count_q != '0);

  always_comb begin
    instr_pres = NOP_INSTR;
    vld        = 1'b0;
    if (has_entry) begin
      instr_pres = mem_q[head_q];
      vld        = 1'b1;
    end else if (q_if.instr_en_i) begin
      instr_pres = q_if.instr_i;
      vld        = 1'b1;
    end
  end

  always_comb begin
    pop           = vld & ~q_if.stall_i & ~q_if.flush_i;
    pop_entry     = pop & has_entry;
    bypass        = pop & ~has_entry;
    push_tail_req = q_if.instr_en_i & ~q_if.flush_i & ~bypass;
    push_head_req = q_if.self_instr_en_i & ~q_if.stall_i & ~q_if.flush_i;

    // Head push claims the last free slot first, so the tail push is the one dropped when full.
    cnt_after  = count_q - CW'(pop_entry);
    free_slots = DEPTH_C - cnt_after;
    push_head  = push_head_req & (free_slots != '0);
    push_tail  = push_tail_req & (free_slots > CW'(push_head));

    head_pop = head_q + ptr_t'(pop_entry);
    head_ins = head_pop - ptr_t'(1);

    head_d  = push_head ? head_ins : head_pop;
    tail_d  = push_tail ? tail_q + ptr_t'(1) : tail_q;
    count_d = cnt_after + CW'(push_head) + CW'(push_tail);
    ovf_d   = ovf_q | (push_head_req & ~push_head) | (push_tail_req & ~push_tail);

    if (q_if.flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage needs no reset; occupancy is tracked solely by count_q.
  always_ff @(posedge clk_i) begin
    if (push_head) mem_q[head_ins] <= q_if.self_instr_i;
    if (push_tail) mem_q[tail_q]   <= q_if.instr_i;
  end

  assign q_if.instr_o       = instr_pres;
  assign q_if.instr_valid_o = vld;
  assign q_if.count_o       = count_q;
  assign q_if.stall_fetch_o = (count_q >= (DEPTH_C - CW'(1)));
  assign q_if.overflow_o    = ovf_q;
endmodule

// File: doc/decode_iqueue.md
DECODE_IQUEUE -- requirements
Module: decode_iqueue

Interface
REQ-001 Parameter INSTR_W, default 16, instruction width in bits.
REQ-002 Parameter DEPTH, default 4, queue entries; legal values are powers of two >= 2.
REQ-003 Parameter NOP_INSTR, default 16'hffff (INSTR_W bits), value presented when there is no valid instruction.
REQ-004 clk_i  input  1  single clock; all state SHALL update on the rising edge.
REQ-005 rst_i  input  1  asynchronous, active-low reset.
REQ-006 instr_i  input  INSTR_W  fetched instruction.
REQ-007 instr_en_i  input  1  instr_i is valid this cycle.
REQ-008 self_instr_i  input  INSTR_W  control-unit generated follow-up instruction.
REQ-009 self_instr_en_i  input  1  self_instr_i is valid; it SHALL be inserted at the head.
REQ-010 stall_i  input  1  downstream holds; the presented instruction is not consumed.
REQ-011 flush_i  input  1  discard all buffered and incoming instructions.
REQ-012 instr_o  output  INSTR_W  instruction presented to the control unit.
REQ-013 instr_valid_o  output  1  instr_o carries a real instruction.
REQ-014 count_o  output  $clog2(DEPTH)+1  number of occupied entries.
REQ-015 stall_fetch_o  output  1  fetch SHALL NOT present a new instruction next cycle.
REQ-016 overflow_o  output  1  sticky flag: a push was dropped.

Function
REQ-017 Storage SHALL be a circular buffer of DEPTH entries with head and tail pointers that wrap modulo DEPTH.
REQ-018 Presentation (combinational): count>0 -> instr_o=entry[head], valid=1; else instr_en_i -> instr_o=instr_i, valid=1 (zero-latency bypass); else instr_o=NOP_INSTR, valid=0.
REQ-019 pop = instr_valid_o & ~stall_i & ~flush_i; a popped queue entry SHALL advance head by 1.
REQ-020 Bypassed instr_i (count==0, popped) SHALL NOT be written into the queue.
REQ-021 push_tail = instr_en_i & ~flush_i & ~(bypass consumed it); with count>0 the fetched instruction SHALL always be written at tail, then tail+1.
REQ-022 push_head = self_instr_en_i & ~stall_i & ~flush_i; self_instr_i SHALL be written at head-1 (after any pop this cycle), so it is presented next cycle ahead of all older entries.
REQ-023 Simultaneous push_head and push_tail SHALL order the self-instruction before the fetched instruction.
REQ-024 count_next = count + push_head + push_tail - pop (pop counted only for queue entries, not bypass), saturating at DEPTH.
REQ-025 A push that would exceed DEPTH SHALL be dropped (tail push dropped before head push) and SHALL set overflow_o until reset.
REQ-026 stall_fetch_o = (count >= DEPTH-1), reserving one slot for a self-instruction.
REQ-027 flush_i SHALL have priority over all events: next cycle count=0, head=tail=0, incoming instr_i and self_instr_i discarded; overflow_o unaffected.
REQ-028 While flush_i=1, instr_o SHALL still be driven per REQ-018, but nothing is consumed.
REQ-029 stall_i=1 with count>0 SHALL hold instr_o stable across cycles.

Reset
REQ-030 rst_i=0 SHALL immediately force count_o=0, head=tail=0, overflow_o=0, stall_fetch_o=0; entry contents are don't-care.
REQ-031 While reset is asserted and instr_en_i=0, instr_o SHALL be NOP_INSTR and instr_valid_o=0.
REQ-032 Reset asserted mid-operation SHALL discard all buffered entries; first edge after release operates from empty.

Verification
REQ-033 Bypass: empty, instr_en_i=1 instr_i=16'h1234, stall_i=0 -> instr_o=16'h1234 same cycle, count_o stays 0.
REQ-034 Stall capture: empty, stall_i=1, instr_i=16'hA001 valid -> next cycle count_o=1, instr_o=16'hA001 held until stall_i=0, then count_o=0.
REQ-035 Self-instruction priority: queue holds 16'h0001,16'h0002; pop 0001 with self_instr_i=16'hBEEF -> next instr_o=16'hBEEF, then 0002.
REQ-036 Full/overflow (DEPTH=4): stall_i=1, push 4 fetches -> stall_fetch_o=1 at count 3, count_o=4; fifth push dropped, overflow_o=1 and sticky.
REQ-037 Wrap-around: push/pop 10 instructions 16'h0000..16'h0009 with random stall_i -> output order exact, no loss, pointers wrap.
REQ-038 Flush and reset: count_o=3, flush_i=1 with instr_en_i=1 -> next cycle count_o=0, valid=0; repeat with rst_i=0 pulse mid-cycle -> outputs reset asynchronously.
